// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side handshake bundle.
// Ports: i_req_valid/o_req_ready/i_req_data/i_req_lock (requesters),
//        o_tx_valid/i_tx_ready/o_tx_data (UART transmitter). Names are from the arbiter's view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   i_req_valid;
  logic [N_REQ-1:0]   o_req_ready;
  logic [N_REQ*8-1:0] i_req_data;
  logic [N_REQ-1:0]   i_req_lock;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic [7:0]         o_tx_data;

  // Arbiter side.
  modport slave (
    input  i_req_valid, i_req_data, i_req_lock, i_tx_ready,
    output o_req_ready, o_tx_valid, o_tx_data
  );

  // Requester/transmitter side (the environment around the arbiter).
  modport master (
    output i_req_valid, i_req_data, i_req_lock, i_tx_ready,
    input  o_req_ready, o_tx_valid, o_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin N-way byte arbiter with lock and inter-frame gap feeding one UART transmitter.
// Latency: accept in IDLE (combinational ready), o_tx_valid one cycle later; one byte per 2 cycles at best.
// Backpressure: byte held on o_tx_data until i_tx_ready; o_req_ready is 0 outside IDLE, so requesters stall.
// Ports: i_clk, i_nrst (async active-low), i_enable, i_gap_cycles, bus (uart_tx_arbiter_if.slave),
//        o_grant (one-hot owner of current/last byte), o_locked, o_busy (SEND or GAP).
// Option: define UART_TX_ARBITER_STATS_EN to add i_stat_clr and o_stat_bytes (16-bit saturating per requester).
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int GAP_W = 16
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_enable,
  input  logic [GAP_W-1:0] i_gap_cycles,
  uart_tx_arbiter_if.slave bus,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_locked,
  output logic             o_busy
`ifdef UART_TX_ARBITER_STATS_EN
  ,
  input  logic              i_stat_clr,
  output logic [N_REQ*16-1:0] o_stat_bytes
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic [N_REQ-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;
  logic             r_locked;
  logic             r_busy;
  logic [GAP_W-1:0] r_gap_cnt;

  logic             w_win_vld;
  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_cand;
  logic [7:0]       w_win_dat;
  logic             w_win_lock;
  logic [N_REQ-1:0] w_win_onehot;
  logic             w_accept;
  logic             w_send_hs;

  // Winner search. With the lock held only the previous owner is eligible,
  // even if it is not presenting a byte. Otherwise scan downwards from the
  // farthest candidate so the nearest valid after last_grant is kept.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    if (r_locked) begin
      w_win_vld = bus.i_req_valid[r_last_grant];
      w_win_idx = r_last_grant;
    end else begin
      for (int i = N_REQ; i >= 1; i--) begin
        w_cand = IDX_W'((int'(r_last_grant) + i) % N_REQ);
        if (bus.i_req_valid[w_cand]) begin
          w_win_vld = 1'b1;
          w_win_idx = w_cand;
        end
      end
    end
  end

  always_comb begin
    w_win_dat = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win_idx == IDX_W'(k)) begin
        w_win_dat = bus.i_req_data[k*8 +: 8];
      end
    end
  end

  assign w_win_lock   = bus.i_req_lock[w_win_idx];
  assign w_win_onehot = N_REQ'(1) << w_win_idx;
  assign w_accept     = (r_state == IDLE) && i_enable && w_win_vld;
  assign w_send_hs    = (r_state == SEND) && bus.i_tx_ready;

  // Ready is combinational from IDLE; qualify with reset so no requester
  // believes its byte was taken while the arbiter is held in reset.
  assign bus.o_req_ready = (w_accept && i_nrst) ? w_win_onehot : '0;
  assign bus.o_tx_valid  = r_tx_valid;
  assign bus.o_tx_data   = r_tx_data;
  assign o_grant         = r_grant;
  assign o_locked        = r_locked;
  assign o_busy          = r_busy;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= IDLE;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_locked     <= 1'b0;
      r_busy       <= 1'b0;
      r_gap_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tx_data    <= w_win_dat;
            r_tx_valid   <= 1'b1;
            r_grant      <= w_win_onehot;
            r_last_grant <= w_win_idx;
            r_locked     <= w_win_lock;
            r_busy       <= 1'b1;
            r_state      <= SEND;
          end
        end
        SEND: begin
          if (bus.i_tx_ready) begin
            r_tx_valid <= 1'b0;
            if (i_gap_cycles == '0) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_gap_cnt <= i_gap_cycles;
              r_state   <= GAP;
            end
          end
        end
        GAP: begin
          // Counter holds the cycles left including this one.
          if (r_gap_cnt <= GAP_W'(1)) begin
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_ARBITER_STATS_EN
  logic [15:0] r_stat [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
        r_stat[g] <= 16'h0000;
      end else if (i_stat_clr) begin
        r_stat[g] <= 16'h0000;
      end else if (w_send_hs && r_grant[g] && (r_stat[g] != 16'hFFFF)) begin
        r_stat[g] <= r_stat[g] + 16'h0001;
      end
    end
    assign o_stat_bytes[g*16 +: 16] = r_stat[g];
  end
`else
  logic w_unused_hs;
  assign w_unused_hs = w_send_hs;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  logic        i_clk;
  logic        i_nrst;
  logic        i_enable;
  logic [15:0] i_gap_cycles;
  logic [3:0]  o_grant;
  logic        o_locked;
  logic        o_busy;
`ifdef UART_TX_ARBITER_STATS_EN
  logic        i_stat_clr;
  logic [63:0] o_stat_bytes;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .GAP_W(16)) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_enable     (i_enable),
    .i_gap_cycles (i_gap_cycles),
    .bus          (bus),
    .o_grant      (o_grant),
    .o_locked     (o_locked),
    .o_busy       (o_busy)
`ifdef UART_TX_ARBITER_STATS_EN
    ,
    .i_stat_clr   (i_stat_clr),
    .o_stat_bytes (o_stat_bytes)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txv"},   32'(bus.o_tx_valid),  32'h0);
    chk({tag, "_txd"},   32'(bus.o_tx_data),   32'h0);
    chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'h0);
    chk({tag, "_grant"}, 32'(o_grant),         32'h0);
    chk({tag, "_lock"},  32'(o_locked),        32'h0);
    chk({tag, "_busy"},  32'(o_busy),          32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_nrst          = 1'b0;
    i_enable        = 1'b1;
    i_gap_cycles    = 16'd0;
    bus.i_req_valid = 4'b1111;
    bus.i_req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.i_req_lock  = 4'b0000;
    bus.i_tx_ready  = 1'b1;
`ifdef UART_TX_ARBITER_STATS_EN
    i_stat_clr      = 1'b0;
`endif
    repeat (3) step();
    chk_reset_vals("rst");

    // Round robin, all valid, gap 0: 0,1,2,3,0 one byte every 2 cycles.
    i_nrst = 1'b1;
    #1;
    chk("rr_first_ready", 32'(bus.o_req_ready), 32'h1);
    for (int n = 0; n < 5; n++) begin
      chk("rr_ready", 32'(bus.o_req_ready), 32'(4'b0001 << (n % 4)));
      step();
      chk("rr_txv",        32'(bus.o_tx_valid),  32'h1);
      chk("rr_txd",        32'(bus.o_tx_data),   32'(8'h10 + (n % 4)));
      chk("rr_grant",      32'(o_grant),         32'(4'b0001 << (n % 4)));
      chk("rr_send_ready", 32'(bus.o_req_ready), 32'h0);
      chk("rr_busy",       32'(o_busy),          32'h1);
      step();
      chk("rr_idle_txv",   32'(bus.o_tx_valid),  32'h0);
      chk("rr_idle_busy",  32'(o_busy),          32'h0);
    end

    // Lock: req1 sends A5 locked, idles a cycle, then 5A unlocked; req2 next.
    bus.i_req_valid      = 4'b0111;
    bus.i_req_data[15:8] = 8'hA5;
    bus.i_req_lock       = 4'b0010;
    #1;
    chk("lk_ready_a5", 32'(bus.o_req_ready), 32'h2);
    step();
    chk("lk_txd_a5",   32'(bus.o_tx_data), 32'hA5);
    chk("lk_locked",   32'(o_locked),      32'h1);
    chk("lk_grant",    32'(o_grant),       32'h2);
    bus.i_req_data[15:8] = 8'h5A;
    bus.i_req_lock       = 4'b0000;
    bus.i_req_valid      = 4'b0101;
    step();
    chk("lk_hold_ready0", 32'(bus.o_req_ready), 32'h0);
    chk("lk_hold_locked", 32'(o_locked),        32'h1);
    step();
    chk("lk_hold_ready1", 32'(bus.o_req_ready), 32'h0);
    bus.i_req_valid = 4'b0111;
    #1;
    chk("lk_ready_5a", 32'(bus.o_req_ready), 32'h2);
    step();
    chk("lk_txd_5a",   32'(bus.o_tx_data), 32'h5A);
    chk("lk_unlocked", 32'(o_locked),      32'h0);
    step();
    chk("lk_next_req2", 32'(bus.o_req_ready), 32'h4);
    step();
    chk("lk_txd_req2",   32'(bus.o_tx_data), 32'h12);
    chk("lk_grant_req2", 32'(o_grant),       32'h4);

    // Gap of 3 cycles after the req2 handshake.
    i_gap_cycles    = 16'd3;
    bus.i_req_valid = 4'b1000;
    for (int g = 0; g < 3; g++) begin
      step();
      chk("gap_busy",  32'(o_busy),          32'h1);
      chk("gap_txv",   32'(bus.o_tx_valid),  32'h0);
      chk("gap_ready", 32'(bus.o_req_ready), 32'h0);
    end
    step();
    chk("gap_end_busy",  32'(o_busy),          32'h0);
    chk("gap_end_ready", 32'(bus.o_req_ready), 32'h8);
    step();
    chk("gap_txd_req3", 32'(bus.o_tx_data), 32'h13);

    // Transmitter stall for 10 cycles; requester inputs change meanwhile.
    bus.i_tx_ready        = 1'b0;
    i_gap_cycles          = 16'd0;
    bus.i_req_valid       = 4'b0111;
    bus.i_req_data[31:24] = 8'hEE;
    for (int s = 0; s < 10; s++) begin
      step();
      chk("stall_txv",   32'(bus.o_tx_valid),  32'h1);
      chk("stall_txd",   32'(bus.o_tx_data),   32'h13);
      chk("stall_ready", 32'(bus.o_req_ready), 32'h0);
    end

    // Disable mid-SEND: the byte completes, then no grants.
    bus.i_tx_ready = 1'b1;
    i_enable       = 1'b0;
    step();
    chk("dis_txv",   32'(bus.o_tx_valid),  32'h0);
    chk("dis_busy",  32'(o_busy),          32'h0);
    chk("dis_ready", 32'(bus.o_req_ready), 32'h0);
    for (int d = 0; d < 4; d++) begin
      step();
      chk("dis_hold_ready", 32'(bus.o_req_ready), 32'h0);
      chk("dis_hold_busy",  32'(o_busy),          32'h0);
    end

    // Re-enable with req0 locking, then reset during GAP.
    i_enable       = 1'b1;
    bus.i_req_lock = 4'b0001;
    i_gap_cycles   = 16'd5;
    #1;
    chk("en_ready", 32'(bus.o_req_ready), 32'h1);
    step();
    chk("en_txd",    32'(bus.o_tx_data), 32'h10);
    chk("en_locked", 32'(o_locked),      32'h1);
    step();
    chk("rgap_busy",   32'(o_busy),     32'h1);
    chk("rgap_locked", 32'(o_locked),   32'h1);
    step();
    i_nrst          = 1'b0;
    bus.i_req_lock  = 4'b0000;
    i_gap_cycles    = 16'd0;
    bus.i_req_valid = 4'b1111;
    #1;
    chk_reset_vals("rgap");
    step();
    i_nrst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.o_req_ready), 32'h1);
    step();
    chk("post_rst_grant", 32'(o_grant),       32'h1);
    chk("post_rst_lock",  32'(o_locked),      32'h0);
    chk("post_rst_txd",   32'(bus.o_tx_data), 32'h10);
    step();
    chk("post_rst_next", 32'(bus.o_req_ready), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
